// File: rtl/fruit_launcher.sv
// Launch scheduler: round-robin slot pick, LFSR-drawn column/angle, one-cycle
// launch pulse per fruit, act handshake with timeout, randomised frame gap.

// Per-slot launch parameter holder. Values only move on a load for this slot,
// so a generator always samples stable data around its launch edge.
module fruit_slot (
  input  logic       sysck,
  input  logic       clr,
  input  logic       ld,
  input  logic [4:0] xin_d,
  input  logic [4:0] theta_d,
  output logic [4:0] xin,
  output logic [4:0] theta
);
  // Hold column/angle; clear with the scheduler, load on accept.
  always_ff @(posedge sysck) begin
    if (clr) begin
      xin   <= '0;
      theta <= '0;
    end else if (ld) begin
      xin   <= xin_d;
      theta <= theta_d;
    end
  end
endmodule

module fruit_launcher #(
  parameter int          NUM_SLOTS   = 4,
  parameter int          GAP_TICKS   = 60,
  parameter int          JITTER_BITS = 5,
  parameter int          THETA_MIN   = 4,
  parameter int          THETA_MAX   = 28,
  parameter int          ACK_CYCLES  = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                   sysck,
  input  logic                   reset,
  input  logic                   on,
  input  logic                   coordck,
  input  logic [NUM_SLOTS-1:0]   act,
  output logic [NUM_SLOTS-1:0]   launch,
  output logic [5*NUM_SLOTS-1:0] xin_o,
  output logic [5*NUM_SLOTS-1:0] theta_o,
  output logic [15:0]            launch_cnt,
  output logic [7:0]             miss_cnt,
  output logic                   busy
);
  localparam int TW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int AW = (ACK_CYCLES > 0) ? $clog2(ACK_CYCLES + 1) : 1;
  localparam int GW = 11;
  localparam logic [7:0] JMASK = 8'((1 << JITTER_BITS) - 1);
  localparam logic [4:0] TMIN  = 5'(THETA_MIN);
  localparam logic [4:0] TMAX  = 5'(THETA_MAX);
  localparam logic [4:0] TMID  = 5'((THETA_MIN + THETA_MAX) >> 1);

  typedef enum logic [2:0] {IDLE, GAP, PICK, LOAD, FIRE, WAIT_ACT} state_t;

  state_t              state, state_n;
  logic                clr;
  logic [15:0]         lfsr;
  logic                fb;
  logic                prev_ck, tick;
  logic [GW-1:0]       gap_cnt;
  logic [TW-1:0]       rr_ptr, target, pick;
  logic                found;
  logic [1:0]          retry;
  logic [AW-1:0]       ack_cnt;
  logic [4:0]          cand, theta_sel;
  logic                cand_ok, accept;
  logic [NUM_SLOTS-1:0] launch_n, ld_vec;
  logic [NUM_SLOTS-1:0][4:0] xin_q, theta_q;

  // Game off behaves exactly like reset.
  assign clr     = reset | ~on;
  assign fb      = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign tick    = coordck & ~prev_ck;
  assign cand    = lfsr[9:5];
  assign cand_ok = (cand >= TMIN) && (cand <= TMAX);
  assign busy    = (state != IDLE);
  assign xin_o   = xin_q;
  assign theta_o = theta_q;

  // Round-robin search for a free slot, starting just after the last launched one.
  always_comb begin
    logic [TW-1:0] jj;
    found = 1'b0;
    pick  = rr_ptr;
    jj    = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      jj = TW'((int'(rr_ptr) + i) % NUM_SLOTS);
      if (!found && !act[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  // Next state, angle acceptance and the launch pulse to be registered.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    theta_sel = cand;
    launch_n  = '0;
    ld_vec    = '0;
    case (state)
      IDLE:     state_n = GAP;
      GAP:      if (gap_cnt == '0) state_n = PICK;
      PICK:     if (found) state_n = LOAD;
      LOAD: begin
        if (cand_ok) begin
          accept = 1'b1;
        end else if (retry == 2'd3) begin
          // Fourth bad draw: fall back to the middle of the legal range.
          accept    = 1'b1;
          theta_sel = TMID;
        end
        if (accept) begin
          state_n        = FIRE;
          ld_vec[target] = 1'b1;
        end
      end
      FIRE:     state_n = WAIT_ACT;
      WAIT_ACT: if (act[target] || ack_cnt == '0) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (state_n == FIRE) launch_n[target] = 1'b1;
  end

  // State register.
  always_ff @(posedge sysck) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath: LFSR, edge detect, counters, registered launch pulse.
  always_ff @(posedge sysck) begin
    if (clr) begin
      lfsr       <= SEED;
      prev_ck    <= 1'b0;
      rr_ptr     <= TW'(NUM_SLOTS - 1);
      target     <= '0;
      gap_cnt    <= '0;
      retry      <= '0;
      ack_cnt    <= '0;
      launch     <= '0;
      launch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      lfsr    <= {fb, lfsr[15:1]};
      prev_ck <= coordck;
      launch  <= launch_n;
      case (state)
        IDLE: gap_cnt <= GW'(GAP_TICKS) + GW'(lfsr[7:0] & JMASK);
        GAP:  if (gap_cnt != '0 && tick) gap_cnt <= gap_cnt - 1'b1;
        PICK: begin
          target <= pick;
          retry  <= '0;
        end
        LOAD: if (!accept) retry <= retry + 1'b1;
        FIRE: begin
          rr_ptr  <= target;
          ack_cnt <= AW'(ACK_CYCLES);
          if (launch_cnt != '1) launch_cnt <= launch_cnt + 1'b1;
        end
        WAIT_ACT: begin
          if (!act[target]) begin
            if (ack_cnt == '0) begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end else begin
              ack_cnt <= ack_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    fruit_slot u_slot (
      .sysck   (sysck),
      .clr     (clr),
      .ld      (ld_vec[k]),
      .xin_d   (lfsr[4:0]),
      .theta_d (theta_sel),
      .xin     (xin_q[k]),
      .theta   (theta_q[k])
    );
  end
endmodule
